// File: rtl/saxis_chk_pkg.sv
// Shared types and constants for the AXI4-Stream frame checker: FSM states,
// error-flag bit positions, LFSR feedback taps and a ceil(log2) helper.
package saxis_chk_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam int ERR_TLAST_EARLY   = 0;
    localparam int ERR_TLAST_MISSING = 1;
    localparam int ERR_SOF           = 2;
    localparam int ERR_STRB          = 3;
    localparam int ERR_DATA          = 4;
    localparam int ERR_W             = 5;

    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback = b0^b2^b3^b5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int clogb2(input int value);
        int v;
        int r;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/saxis_ready_lfsr.sv
// TREADY source for the frame checker: a free-running 16-bit Fibonacci LFSR
// whose bit 0 becomes the registered ready when STALL_EN is set.
module saxis_ready_lfsr
    import saxis_chk_pkg::*;
#(
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    output logic ready
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        ready_q;
    logic        ready_d;

    // Ready is its own flop so it reads 0 while reset is held, independent of the seed.
    always_comb begin
        lfsr_d  = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        ready_d = (STALL_EN != 0) ? lfsr_q[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

endmodule

// File: rtl/saxis_frame_checker.sv
// AXI4-Stream video sink: checks TUSER/TLAST framing, counts lines and frames,
// and keeps sticky error flags. Define SAXIS_CHK_PATTERN_EN to add the TDATA pattern check.
module saxis_frame_checker
    import saxis_chk_pkg::*;
#(
    parameter int          C_S_AXIS_TDATA_WIDTH = 32,
    parameter int          PIXELS_HORIZONTAL    = 1280,
    parameter int          PIXELS_VERTICAL      = 1024,
    parameter int          STALL_EN             = 0,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TUSER,
    input  logic                              err_clr,
    output logic [15:0]                       frame_cnt,
    output logic [11:0]                       line_cnt,
    output logic                              frame_done,
    output logic [4:0]                        err_status,
    output logic [15:0]                       err_count
);

    localparam int                WORDS     = PIXELS_HORIZONTAL / 4;
    localparam int                PIX_W     = clogb2(WORDS);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(WORDS - 1);
    localparam logic [11:0]       LAST_LINE = 12'(PIXELS_VERTICAL - 1);

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [11:0]        line_q, line_d;
    logic [15:0]        frame_q, frame_d;
    logic               done_q, done_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [15:0]        ecnt_q, ecnt_d;

    logic               tready;
    logic               acc;
    logic               checked;
    logic               line_end;
    logic [PIX_W-1:0]   pix_eff;
    logic [11:0]        line_eff;
    logic [ERR_W-1:0]   beat_err;

    saxis_ready_lfsr #(
        .STALL_EN  (STALL_EN),
        .LFSR_SEED (LFSR_SEED)
    ) u_ready (
        .clk   (S_AXIS_ACLK),
        .rst_n (S_AXIS_ARESETN),
        .ready (tready)
    );

`ifdef SAXIS_CHK_PATTERN_EN
    logic [3:0] fexp_q, fexp_d;
    logic [3:0] fexp_eff;
`else
    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA;
`endif

    // A TUSER beat always restarts at pixel 0 of line 0, whether it opens or resyncs a frame.
    always_comb begin
        acc      = S_AXIS_TVALID & tready;
        checked  = acc & ((state_q == ACTIVE) | S_AXIS_TUSER);
        pix_eff  = S_AXIS_TUSER ? '0 : pix_q;
        line_eff = S_AXIS_TUSER ? '0 : line_q;
        line_end = (pix_eff == LAST_PIX) | S_AXIS_TLAST;

        beat_err                    = '0;
        beat_err[ERR_SOF]           = (state_q == ACTIVE) & S_AXIS_TUSER &
                                      ((line_q != '0) | (pix_q != '0));
        beat_err[ERR_TLAST_MISSING] = (pix_eff == LAST_PIX) & ~S_AXIS_TLAST;
        beat_err[ERR_TLAST_EARLY]   = (pix_eff != LAST_PIX) & S_AXIS_TLAST;
        beat_err[ERR_STRB]          = (S_AXIS_TSTRB != '1);
`ifdef SAXIS_CHK_PATTERN_EN
        fexp_eff                    = S_AXIS_TUSER ? frame_q[3:0] : fexp_q;
        beat_err[ERR_DATA]          = (S_AXIS_TDATA != {fexp_eff, line_eff, 16'(pix_eff)});
`endif
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        line_d  = line_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ecnt_d  = ecnt_q;

        if (checked) begin
            state_d = ACTIVE;
            if (line_end) begin
                pix_d = '0;
                if (line_eff == LAST_LINE) begin
                    line_d  = '0;
                    frame_d = frame_q + 16'd1;
                    done_d  = 1'b1;
                    state_d = WAIT_SOF;
                end else begin
                    line_d = line_eff + 12'd1;
                end
            end else begin
                pix_d  = pix_eff + PIX_W'(1);
                line_d = line_eff;
            end

            err_d = err_q | beat_err;
            if ((beat_err != '0) && (ecnt_q != 16'hFFFF)) begin
                ecnt_d = ecnt_q + 16'd1;
            end
        end

        if (err_clr) begin
            err_d  = '0;
            ecnt_d = '0;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= WAIT_SOF;
            pix_q   <= '0;
            line_q  <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

`ifdef SAXIS_CHK_PATTERN_EN
    // Frame tag for the pattern is captured on every SOF beat, including resyncs.
    always_comb begin
        fexp_d = fexp_q;
        if (checked && S_AXIS_TUSER) begin
            fexp_d = frame_q[3:0];
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            fexp_q <= '0;
        end else begin
            fexp_q <= fexp_d;
        end
    end
`endif

    assign S_AXIS_TREADY = tready;
    assign frame_cnt     = frame_q;
    assign line_cnt      = line_q;
    assign frame_done    = done_q;
    assign err_status    = err_q;
    assign err_count     = ecnt_q;

endmodule

// File: tb/tb_saxis_frame_checker.sv
// Bench for saxis_frame_checker (H=16, V=3): directed vector table, random
// error stream against a per-beat model, and LFSR backpressure with async reset.
module tb_saxis_frame_checker;

    localparam int          H     = 16;
    localparam int          V     = 3;
    localparam int          WORDS = H / 4;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef SAXIS_CHK_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast, tuser, err_clr;
    logic        tvalid0, tvalid1;

    logic        tready0, frame_done0, tready1, frame_done1;
    logic [15:0] frame_cnt0, err_count0, frame_cnt1, err_count1;
    logic [11:0] line_cnt0, line_cnt1;
    logic [4:0]  err_status0, err_status1;

    always #5 clk = ~clk;

    saxis_frame_checker #(
        .C_S_AXIS_TDATA_WIDTH(32), .PIXELS_HORIZONTAL(H), .PIXELS_VERTICAL(V),
        .STALL_EN(0), .LFSR_SEED(SEED)
    ) dut0 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TVALID(tvalid0),
        .S_AXIS_TREADY(tready0), .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb),
        .S_AXIS_TLAST(tlast), .S_AXIS_TUSER(tuser), .err_clr(err_clr),
        .frame_cnt(frame_cnt0), .line_cnt(line_cnt0), .frame_done(frame_done0),
        .err_status(err_status0), .err_count(err_count0)
    );

    saxis_frame_checker #(
        .C_S_AXIS_TDATA_WIDTH(32), .PIXELS_HORIZONTAL(H), .PIXELS_VERTICAL(V),
        .STALL_EN(1), .LFSR_SEED(SEED)
    ) dut1 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TVALID(tvalid1),
        .S_AXIS_TREADY(tready1), .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb),
        .S_AXIS_TLAST(tlast), .S_AXIS_TUSER(tuser), .err_clr(err_clr),
        .frame_cnt(frame_cnt1), .line_cnt(line_cnt1), .frame_done(frame_done1),
        .err_status(err_status1), .err_count(err_count1)
    );

    // Reference model state, advanced once per accepted beat.
    int       errors = 0;
    int       checks = 0;
    bit       sel    = 1'b0;
    int       cyc    = 0;
    bit       lfsr_bit [0:4095];
    bit       m_in_frame;
    int       m_line, m_pix, m_frames, m_fexp, m_errcnt;
    logic [4:0] m_err;
    bit       m_done;

    typedef struct {
        bit         v, u, l;
        logic [3:0] s;
        bit         flip, c;
        int         e_line;
        logic [4:0] e_err;
        int         e_cnt;
        bit         e_done;
        int         e_frame;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    function automatic vec_t mk(bit v, bit u, bit l, logic [3:0] s, bit flip, bit c,
                                int el, logic [4:0] ee, int ec, bit ed, int ef);
        vec_t t;
        t.v = v; t.u = u; t.l = l; t.s = s; t.flip = flip; t.c = c;
        t.e_line = el; t.e_err = ee; t.e_cnt = ec; t.e_done = ed; t.e_frame = ef;
        return t;
    endfunction

    function automatic logic [31:0] pat(int f, int ln, int px);
        return {4'(f), 12'(ln), 16'(px)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0; m_line = 0; m_pix = 0; m_frames = 0; m_fexp = 0;
        m_errcnt = 0; m_err = '0; m_done = 1'b0;
    endtask

    task automatic model_beat(input bit u, input bit l, input logic [3:0] s, input logic [31:0] d);
        logic [4:0] e;
        bit last_pos;
        e = '0;
        if (m_in_frame || u) begin
            if (u) begin
                if (m_in_frame && (m_line != 0 || m_pix != 0)) e[2] = 1'b1;
                m_line = 0; m_pix = 0; m_fexp = m_frames % 16; m_in_frame = 1'b1;
            end
            last_pos = (m_pix == WORDS - 1);
            if (s != 4'hF) e[3] = 1'b1;
            if (PAT_EN && d != pat(m_fexp, m_line, m_pix)) e[4] = 1'b1;
            if (last_pos && !l) e[1] = 1'b1;
            if (!last_pos && l) e[0] = 1'b1;
            if (last_pos || l) begin
                m_pix = 0;
                if (m_line == V - 1) begin
                    m_line = 0; m_frames = (m_frames + 1) % 65536;
                    m_done = 1'b1; m_in_frame = 1'b0;
                end else begin
                    m_line++;
                end
            end else begin
                m_pix++;
            end
            m_err = m_err | e;
            if (e != 0 && m_errcnt < 65535) m_errcnt++;
        end
    endtask

    task automatic compare_outputs();
        if (sel) begin
            chk("line_cnt", line_cnt1, m_line);
            chk("frame_cnt", frame_cnt1, m_frames);
            chk("err_status", err_status1, m_err);
            chk("err_count", err_count1, m_errcnt);
            chk("frame_done", frame_done1, m_done);
        end else begin
            chk("line_cnt", line_cnt0, m_line);
            chk("frame_cnt", frame_cnt0, m_frames);
            chk("err_status", err_status0, m_err);
            chk("err_count", err_count0, m_errcnt);
            chk("frame_done", frame_done0, m_done);
        end
        chk("tready_nostall", tready0, 1);
        if (cyc >= 1 && cyc <= 4096) chk("tready_lfsr", tready1, lfsr_bit[cyc-1]);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input bit v, input bit u, input bit l, input logic [3:0] s,
                        input logic [31:0] d, input bit c, output bit acc);
        bit rdy;
        rdy     = sel ? tready1 : tready0;
        tvalid0 = v && !sel;
        tvalid1 = v && sel;
        tuser = u; tlast = l; tstrb = s; tdata = d; err_clr = c;
        acc = v && rdy;
        @(posedge clk);
        cyc++;
        m_done = 1'b0;
        if (acc) model_beat(u, l, s, d);
        if (c) begin m_err = '0; m_errcnt = 0; end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        bit acc;
        rst_n = 1'b0;
        tvalid0 = 0; tvalid1 = 0; tuser = 0; tlast = 0; tstrb = 4'hF; tdata = '0; err_clr = 0;
        repeat (2) @(negedge clk);
        chk("rst_tready0", tready0, 0);
        chk("rst_tready1", tready1, 0);
        chk("rst_line", {line_cnt0, line_cnt1}, 0);
        chk("rst_frame", {frame_cnt0, frame_cnt1}, 0);
        chk("rst_err", {err_status0, err_count0, err_status1, frame_done0, frame_done1}, 0);
        rst_n = 1'b1;
        cyc = 0;
        model_reset();
        step(0, 0, 0, 4'hF, 0, 0, acc);
    endtask

    // Correct-pattern generator that holds each beat until accepted.
    task automatic run_gen(input int nbeats, output int dn);
        int  b, budget, f, ln, px;
        bit  pend, acc;
        b = 0; budget = 0; pend = 0; dn = 0;
        while (b < nbeats && budget < 4000) begin
            f = b / (WORDS * V); ln = (b / WORDS) % V; px = b % WORDS;
            if (!pend) pend = ($urandom % 4) != 0;
            step(pend, pend && ln == 0 && px == 0, pend && px == WORDS - 1, 4'hF,
                 pat(f, ln, px), 0, acc);
            if (acc) begin pend = 0; b++; end
            if (sel ? frame_done1 : frame_done0) dn++;
            budget++;
        end
        chk("gen_beats_sent", b, nbeats);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        vec_t        t;
        logic [31:0] d;
        bit          acc, u, l, c;
        logic [3:0]  st;
        int          dn;

        s = SEED;
        for (int k = 0; k < 4096; k++) begin
            lfsr_bit[k] = s[0];
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end

        //          v u l strb flip clr line err       cnt        done frame
        tbl[0]  = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[1]  = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[2]  = mk(1,0,1,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[3]  = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[4]  = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[5]  = mk(1,1,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[6]  = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[7]  = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[8]  = mk(1,0,1,4'hF,0,0, 1,5'b00000,0,0,0);
        tbl[9]  = mk(1,0,0,4'hF,0,0, 1,5'b00000,0,0,0);
        tbl[10] = mk(1,1,0,4'hF,0,0, 0,5'b00100,1,0,0);
        tbl[11] = mk(0,0,0,4'hF,0,1, 0,5'b00000,0,0,0);
        tbl[12] = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[13] = mk(1,0,0,4'hF,0,0, 0,5'b00000,0,0,0);
        tbl[14] = mk(1,0,1,4'hF,0,0, 1,5'b00000,0,0,0);
        tbl[15] = mk(1,0,0,4'hF,0,0, 1,5'b00000,0,0,0);
        tbl[16] = mk(1,0,0,4'hF,0,0, 1,5'b00000,0,0,0);
        tbl[17] = mk(1,0,1,4'hF,0,0, 2,5'b00001,1,0,0);
        tbl[18] = mk(1,0,0,4'hF,0,0, 2,5'b00001,1,0,0);
        tbl[19] = mk(1,0,0,4'hF,0,0, 2,5'b00001,1,0,0);
        tbl[20] = mk(1,0,0,4'hF,0,0, 2,5'b00001,1,0,0);
        tbl[21] = mk(1,0,0,4'hF,0,0, 0,5'b00011,2,1,1);
        tbl[22] = mk(0,0,0,4'hF,0,0, 0,5'b00011,2,0,1);
        tbl[23] = mk(1,1,0,4'hE,0,0, 0,5'b01011,3,0,1);
        tbl[24] = mk(1,0,0,4'hF,1,0, 0,5'b01011 | {PAT_EN,4'b0000},3+int'(PAT_EN),0,1);
        tbl[25] = mk(1,0,0,4'hE,0,1, 0,5'b00000,0,0,1);
        tbl[26] = mk(1,0,1,4'hF,0,0, 1,5'b00000,0,0,1);
        tbl[27] = mk(1,0,0,4'hF,0,0, 1,5'b00000,0,0,1);
        tbl[28] = mk(1,0,0,4'hF,0,0, 1,5'b00000,0,0,1);
        tbl[29] = mk(1,0,0,4'hF,0,0, 1,5'b00000,0,0,1);
        tbl[30] = mk(1,0,0,4'hF,0,0, 2,5'b00010,1,0,1);

        // Clean stream, no stalls: two frames.
        sel = 0;
        do_reset();
        run_gen(2 * WORDS * V, dn);
        chk("clean_done_pulses", dn, 2);
        chk("clean_frame_cnt", frame_cnt0, 2);
        chk("clean_err_status", err_status0, 0);
        chk("clean_err_count", err_count0, 0);

        // Directed framing-error table.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            t = tbl[i];
            d = t.u ? pat(m_frames, 0, 0) : pat(m_fexp, m_line, m_pix);
            if (t.flip) d[0] = ~d[0];
            step(t.v, t.u, t.l, t.s, d, t.c, acc);
            chk($sformatf("vec%0d_line", i), line_cnt0, t.e_line);
            chk($sformatf("vec%0d_err", i), err_status0, t.e_err);
            chk($sformatf("vec%0d_cnt", i), err_count0, t.e_cnt);
            chk($sformatf("vec%0d_done", i), frame_done0, t.e_done);
            chk($sformatf("vec%0d_frame", i), frame_cnt0, t.e_frame);
        end

        // Random stream with injected framing, strobe and data faults.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            u  = (!m_in_frame && ($urandom % 3 == 0)) || ($urandom % 30 == 0);
            l  = ((u ? 0 : m_pix) == WORDS - 1) ^ ($urandom % 12 == 0);
            st = ($urandom % 16 == 0) ? 4'($urandom) : 4'hF;
            d  = u ? pat(m_frames, 0, 0) : pat(m_fexp, m_line, m_pix);
            if ($urandom % 16 == 0) d = d ^ (32'd1 << ($urandom % 32));
            c  = ($urandom % 40 == 0);
            step(($urandom % 4) != 0, u, l, st, d, c, acc);
        end

        // Backpressure from the LFSR, then an asynchronous reset mid-line.
        sel = 1;
        do_reset();
        run_gen(4 * WORDS * V + WORDS + 2, dn);
        chk("bp_done_pulses", dn, 4);
        chk("bp_frame_cnt", frame_cnt1, 4);
        chk("bp_line_cnt", line_cnt1, 1);
        chk("bp_err_status", err_status1, 0);
        chk("bp_err_count", err_count1, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tready", tready1, 0);
        chk("async_rst_line", line_cnt1, 0);
        chk("async_rst_frame", frame_cnt1, 0);
        do_reset();
        run_gen(WORDS * V, dn);
        chk("post_rst_done", dn, 1);
        chk("post_rst_frame", frame_cnt1, 1);
        chk("post_rst_err", err_status1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
